// File: rtl/apb_irq_scheduler.sv
// Interrupt scheduler for the APB subsystem: latches edge sources, masks with enables,
// arbitrates (round-robin or fixed) and presents one line at a time via req/ack/eoi.
module apb_irq_scheduler #(
  parameter int NUM_IRQ = 32,
  parameter int ID_W    = 5,
  parameter bit RR_EN   = 1'b1
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [NUM_IRQ-1:0] irq_en,
  input  logic [NUM_IRQ-1:0] edge_sel,
  input  logic               irq_ack,
  input  logic               irq_eoi,
  output logic               irq_req,
  output logic [ID_W-1:0]    irq_id,
  output logic               in_service,
  output logic [NUM_IRQ-1:0] pending
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  localparam logic [NUM_IRQ-1:0] LINE0 = NUM_IRQ'(1);
  localparam logic [ID_W:0]      NUM_W = (ID_W+1)'(NUM_IRQ);

  state_t             state_r;
  logic [NUM_IRQ-1:0] irq_in_d_r;
  logic [NUM_IRQ-1:0] edge_lat_r;
  logic [ID_W-1:0]    rr_ptr_r;

  logic [NUM_IRQ-1:0] rise_s;
  logic [NUM_IRQ-1:0] eligible_s;
  logic [NUM_IRQ-1:0] id_mask_s;
  logic [NUM_IRQ-1:0] ack_clr_s;
  logic [NUM_IRQ-1:0] rot_s;
  logic [ID_W-1:0]    base_s;
  logic [ID_W-1:0]    off_s;
  logic [ID_W:0]      sum_s;
  logic [ID_W-1:0]    win_id_s;
  logic [ID_W-1:0]    next_ptr_s;
  logic               win_found_s;
  logic               id_hit_s;

  assign rise_s     = irq_in & ~irq_in_d_r & edge_sel;
  assign pending    = (edge_lat_r & edge_sel) | (irq_in & ~edge_sel);
  assign eligible_s = pending & irq_en;
  assign id_mask_s  = LINE0 << irq_id;
  assign id_hit_s   = |(eligible_s & id_mask_s);
  assign ack_clr_s  = ((state_r == REQ) && irq_ack) ? id_mask_s : '0;
  assign next_ptr_s = (irq_id == ID_W'(NUM_IRQ - 1)) ? '0 : irq_id + ID_W'(1);

  // Winner search: rotate so the search origin sits at bit 0, pick the lowest set bit, rotate back
  always_comb begin
    base_s      = RR_EN ? rr_ptr_r : '0;
    rot_s       = (eligible_s >> base_s) | (eligible_s << (NUM_IRQ - int'(base_s)));
    win_found_s = |rot_s;
    off_s       = '0;
    for (int n = NUM_IRQ - 1; n >= 0; n--) begin
      off_s = rot_s[n] ? ID_W'(n) : off_s;
    end
    sum_s    = {1'b0, off_s} + {1'b0, base_s};
    win_id_s = (sum_s >= NUM_W) ? ID_W'(sum_s - NUM_W) : sum_s[ID_W-1:0];
  end

  // Input history and edge latches; a new edge wins over a same-cycle ack clear
  always_ff @(posedge sys_clk) begin
    irq_in_d_r <= irq_in;
    if (sys_rst) begin
      edge_lat_r <= '0;
    end else begin
      edge_lat_r <= (edge_lat_r & ~ack_clr_s & edge_sel) | rise_s;
    end
  end

  // Host handshake FSM with registered outputs
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_r    <= IDLE;
      irq_req    <= 1'b0;
      irq_id     <= '0;
      in_service <= 1'b0;
      rr_ptr_r   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (win_found_s) begin
            irq_id  <= win_id_s;
            irq_req <= 1'b1;
            state_r <= REQ;
          end
        end
        REQ: begin
          if (irq_ack) begin
            irq_req    <= 1'b0;
            in_service <= 1'b1;
            rr_ptr_r   <= next_ptr_s;
            state_r    <= SERVICE;
          end else if (!id_hit_s) begin
            // source vanished before the host took it: retract without touching rr_ptr
            irq_req <= 1'b0;
            state_r <= IDLE;
          end
        end
        SERVICE: begin
          if (irq_eoi) begin
            in_service <= 1'b0;
            state_r    <= IDLE;
          end
        end
        default: begin
          irq_req    <= 1'b0;
          in_service <= 1'b0;
          state_r    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_irq_scheduler.sv
// Bench for apb_irq_scheduler: a round-robin and a fixed-priority instance share stimulus
// and are compared every cycle against a line-level reference model.
module tb_apb_irq_scheduler;

  localparam int N   = 32;
  localparam int IDW = 5;

  logic           sys_clk = 1'b0;
  logic           sys_rst;
  logic [N-1:0]   irq_in;
  logic [N-1:0]   irq_en;
  logic [N-1:0]   edge_sel;
  logic           irq_ack;
  logic           irq_eoi;
  logic [1:0]     dut_req;
  logic [1:0]     dut_svc;
  logic [IDW-1:0] dut_id   [2];
  logic [N-1:0]   dut_pend [2];

  int n_checks = 0;
  int n_pass   = 0;

  // reference model: k = 0 round-robin, k = 1 fixed priority; m_st 0 idle, 1 presenting, 2 servicing
  logic [N-1:0] m_prev [2];
  logic [N-1:0] m_lat  [2];
  int           m_st   [2];
  int           m_id   [2];
  int           m_rr   [2];

  apb_irq_scheduler #(.NUM_IRQ(N), .ID_W(IDW), .RR_EN(1'b1)) u_rr (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .irq_in(irq_in), .irq_en(irq_en),
    .edge_sel(edge_sel), .irq_ack(irq_ack), .irq_eoi(irq_eoi),
    .irq_req(dut_req[0]), .irq_id(dut_id[0]), .in_service(dut_svc[0]), .pending(dut_pend[0])
  );

  apb_irq_scheduler #(.NUM_IRQ(N), .ID_W(IDW), .RR_EN(1'b0)) u_fp (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .irq_in(irq_in), .irq_en(irq_en),
    .edge_sel(edge_sel), .irq_ack(irq_ack), .irq_eoi(irq_eoi),
    .irq_req(dut_req[1]), .irq_id(dut_id[1]), .in_service(dut_svc[1]), .pending(dut_pend[1])
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] model_pending(input int k);
    return (m_lat[k] & edge_sel) | (irq_in & ~edge_sel);
  endfunction

  function automatic int pick(input int k, input logic [N-1:0] e);
    int j;
    for (int n = 0; n < N; n++) begin
      j = (k == 0) ? (m_rr[k] + n) % N : n;
      if (((e >> j) & 32'd1) != 32'd0) return j;
    end
    return 0;
  endfunction

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      logic [N-1:0] elig;
      logic [N-1:0] clr;
      if (sys_rst) begin
        m_st[k]  = 0;
        m_id[k]  = 0;
        m_rr[k]  = 0;
        m_lat[k] = '0;
      end else begin
        elig = model_pending(k) & irq_en;
        clr  = '0;
        if (m_st[k] == 0) begin
          if (elig != '0) begin
            m_id[k] = pick(k, elig);
            m_st[k] = 1;
          end
        end else if (m_st[k] == 1) begin
          if (irq_ack) begin
            clr     = 32'd1 << m_id[k];
            m_rr[k] = (m_id[k] + 1) % N;
            m_st[k] = 2;
          end else if (((elig >> m_id[k]) & 32'd1) == 32'd0) begin
            m_st[k] = 0;
          end
        end else begin
          if (irq_eoi) m_st[k] = 0;
        end
        m_lat[k] = (m_lat[k] & ~clr & edge_sel) | (irq_in & ~m_prev[k] & edge_sel);
      end
      m_prev[k] = irq_in;
    end
  endtask

  // one clock: advance the model with the inputs present at the edge, then compare
  task automatic cycle();
    string nm;
    model_step();
    @(posedge sys_clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      nm = (k == 0) ? "rr" : "fp";
      check({nm, ".req"},  32'(dut_req[k]), 32'(m_st[k] == 1));
      check({nm, ".id"},   32'(dut_id[k]),  m_id[k]);
      check({nm, ".svc"},  32'(dut_svc[k]), 32'(m_st[k] == 2));
      check({nm, ".pend"}, dut_pend[k],     model_pending(k));
    end
  endtask

  task automatic wait_req(input string tag);
    for (int w = 0; w < 16 && dut_req[0] !== 1'b1; w++) cycle();
    check({tag, ".req_seen"}, 32'(dut_req[0]), 32'd1);
  endtask

  task automatic do_ack();
    irq_ack = 1'b1;
    cycle();
    irq_ack = 1'b0;
  endtask

  task automatic do_eoi();
    irq_eoi = 1'b1;
    cycle();
    irq_eoi = 1'b0;
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    cycle();
    cycle();
    sys_rst = 1'b0;
  endtask

  int          rr_exp [4] = '{0, 2, 12, 0};
  logic [N-1:0] mask;

  initial begin
    sys_rst  = 1'b1;
    irq_in   = '0;
    irq_en   = '1;
    edge_sel = '0;
    irq_ack  = 1'b0;
    irq_eoi  = 1'b0;
    cycle();
    cycle();
    check("rst.req", 32'(dut_req[0]), 32'd0);
    check("rst.id",  32'(dut_id[0]),  32'd0);
    check("rst.svc", 32'(dut_svc[0]), 32'd0);
    sys_rst = 1'b0;

    // single edge on line 8, then rr_ptr = 9 shown by lines 3/10 contention
    edge_sel = 32'h0000_0100;
    irq_in   = 32'h0000_0100;
    cycle();
    irq_in = '0;
    cycle();
    check("edge.req", 32'(dut_req[0]), 32'd1);
    check("edge.id",  32'(dut_id[0]),  32'd8);
    do_ack();
    check("edge.pend8", 32'(dut_pend[0][8]), 32'd0);
    check("edge.svc",   32'(dut_svc[0]),     32'd1);
    do_eoi();
    check("edge.eoi_svc", 32'(dut_svc[0]), 32'd0);
    irq_in = (32'd1 << 3) | (32'd1 << 10);
    cycle();
    check("ptr9.rr_id", 32'(dut_id[0]), 32'd10);
    check("ptr9.fp_id", 32'(dut_id[1]), 32'd3);
    irq_in = '0;
    cycle();

    // retract line 4 before ack; rr_ptr must stay at 9
    irq_in = 32'd1 << 4;
    cycle();
    check("retract.id", 32'(dut_id[0]), 32'd4);
    irq_in = '0;
    cycle();
    check("retract.req", 32'(dut_req[0]), 32'd0);
    check("retract.svc", 32'(dut_svc[0]), 32'd0);
    irq_in = (32'd1 << 4) | (32'd1 << 6);
    cycle();
    check("retract.ptr_kept", 32'(dut_id[0]), 32'd4);
    irq_in = '0;
    cycle();

    // round-robin over level lines 0, 2, 12
    do_reset();
    edge_sel = '0;
    irq_in   = (32'd1 << 0) | (32'd1 << 2) | (32'd1 << 12);
    for (int g = 0; g < 4; g++) begin
      wait_req("rr");
      check($sformatf("rr.grant%0d", g), 32'(dut_id[0]), rr_exp[g]);
      check($sformatf("fp.grant%0d", g), 32'(dut_id[1]), 32'd0);
      do_ack();
      do_eoi();
    end
    irq_in = '0;
    cycle();

    // new edge on line 9 while it is in service, and an edge coinciding with the ack
    do_reset();
    edge_sel = 32'd1 << 9;
    irq_in   = 32'd1 << 9;
    cycle();
    irq_in = '0;
    wait_req("e9a");
    check("e9.id", 32'(dut_id[0]), 32'd9);
    do_ack();
    irq_in = 32'd1 << 9;
    cycle();
    irq_in = '0;
    cycle();
    check("e9.svc_pend", 32'(dut_pend[0][9]), 32'd1);
    do_eoi();
    wait_req("e9b");
    check("e9.repres_id", 32'(dut_id[0]), 32'd9);
    irq_in  = 32'd1 << 9;
    irq_ack = 1'b1;
    cycle();
    irq_ack = 1'b0;
    irq_in  = '0;
    check("e9.ackedge_svc",  32'(dut_svc[0]),     32'd1);
    check("e9.ackedge_pend", 32'(dut_pend[0][9]), 32'd1);
    do_eoi();
    wait_req("e9c");
    check("e9.ackedge_id", 32'(dut_id[0]), 32'd9);
    do_ack();
    do_eoi();

    // reset during service with edge line 1 still high
    do_reset();
    edge_sel = 32'd1 << 1;
    irq_in   = 32'd1 << 1;
    cycle();
    wait_req("r1");
    check("r1.id", 32'(dut_id[0]), 32'd1);
    do_ack();
    check("r1.svc", 32'(dut_svc[0]), 32'd1);
    sys_rst = 1'b1;
    cycle();
    check("r1.rst_req",  32'(dut_req[0]),  32'd0);
    check("r1.rst_id",   32'(dut_id[0]),   32'd0);
    check("r1.rst_svc",  32'(dut_svc[0]),  32'd0);
    check("r1.rst_pend", dut_pend[0],      32'd0);
    sys_rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      check("r1.no_req", 32'(dut_req[0]), 32'd0);
    end
    irq_in = '0;
    cycle();
    irq_in = 32'd1 << 1;
    cycle();
    wait_req("r1b");
    check("r1.again_id", 32'(dut_id[0]), 32'd1);
    do_ack();
    irq_in = '0;
    do_eoi();

    // pointer wrap: after line 30, line 31 beats line 0
    do_reset();
    edge_sel = '0;
    irq_in   = 32'd1 << 30;
    wait_req("w30");
    check("wrap.id30", 32'(dut_id[0]), 32'd30);
    do_ack();
    irq_in = (32'd1 << 31) | 32'd1;
    do_eoi();
    wait_req("w31");
    check("wrap.rr_id31", 32'(dut_id[0]), 32'd31);
    check("wrap.fp_id0",  32'(dut_id[1]), 32'd0);
    do_ack();
    irq_in = 32'd1;
    do_eoi();
    wait_req("w0");
    check("wrap.rr_id0", 32'(dut_id[0]), 32'd0);
    do_ack();
    irq_in = '0;
    do_eoi();

    // randomized traffic against the model
    do_reset();
    mask = '0;
    for (int c = 0; c < 2500; c++) begin
      if (c % 64 == 0) begin
        irq_en   = $urandom | $urandom;
        edge_sel = $urandom;
        mask     = '0;
        for (int b = 0; b < 5; b++) mask = mask | (32'd1 << $urandom_range(0, N - 1));
      end
      irq_in  = irq_in ^ ($urandom & $urandom & mask);
      irq_ack = ($urandom_range(0, 2) == 0);
      irq_eoi = ($urandom_range(0, 3) == 0);
      sys_rst = ($urandom_range(0, 299) == 0);
      cycle();
    end
    sys_rst = 1'b0;
    irq_ack = 1'b0;
    irq_eoi = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
